// File: rtl/rgb2gray_pkg.sv
// Shared definitions for the RGB-to-gray stream front end:
// mode encodings, default luma weights, output flag positions.
package rgb2gray_pkg;

  typedef enum logic [1:0] {
    MODE_LUMA  = 2'd0,
    MODE_MAX   = 2'd1,
    MODE_GREEN = 2'd2,
    MODE_RED   = 2'd3
  } mode_e;

  localparam int unsigned COEF_FRAC_DEF = 8;
  localparam int unsigned COEF_R_DEF    = 77;
  localparam int unsigned COEF_G_DEF    = 150;
  localparam int unsigned COEF_B_DEF    = 29;

  // flag offsets above the packed gray pixels
  localparam int unsigned FLAG_SOF = 0;
  localparam int unsigned FLAG_EOL = 1;

endpackage

// File: rtl/rgb2gray_pixel.sv
// One pixel lane: stage 1 registers weighted products and channel picks,
// stage 2 rounds/saturates or scales and registers the gray value.
module rgb2gray_pixel
  import rgb2gray_pkg::*;
#(
  parameter int unsigned CH_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned COEF_FRAC = COEF_FRAC_DEF,
  parameter int unsigned COEF_R    = COEF_R_DEF,
  parameter int unsigned COEF_G    = COEF_G_DEF,
  parameter int unsigned COEF_B    = COEF_B_DEF,
  parameter int unsigned RED_LSB   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [3*CH_WIDTH-1:0] pix_i,
  input  mode_e                 mode_i,
  output logic [OUT_WIDTH-1:0]  gray_o
);

  localparam int PW = CH_WIDTH + COEF_FRAC + 1;
  localparam int SW = PW + 2;
  localparam logic [SW-1:0] RND =
    SW'(1) << (COEF_FRAC - 1);
  localparam logic [SW-1:0] GMAX =
    SW'((1 << OUT_WIDTH) - 1);

  function automatic logic [OUT_WIDTH-1:0] scale(
    input logic [CH_WIDTH-1:0] c
  );
    if (CH_WIDTH >= OUT_WIDTH)
      scale = OUT_WIDTH'(c >> (CH_WIDTH - OUT_WIDTH));
    else
      scale = OUT_WIDTH'(c) << (OUT_WIDTH - CH_WIDTH);
  endfunction

  logic [CH_WIDTH-1:0] r, g, b, mx;
  logic [PW-1:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic [CH_WIDTH-1:0] mx_q, mx_d, g_q, g_d, r_q, r_d;
  mode_e mode_q, mode_d;
  logic [SW-1:0] sum, y;
  logic [OUT_WIDTH-1:0] luma;
  logic [OUT_WIDTH-1:0] gray_q, gray_d;

  always_comb begin
    g = pix_i[2*CH_WIDTH-1:CH_WIDTH];
    if (RED_LSB != 0) begin
      r = pix_i[CH_WIDTH-1:0];
      b = pix_i[3*CH_WIDTH-1:2*CH_WIDTH];
    end else begin
      b = pix_i[CH_WIDTH-1:0];
      r = pix_i[3*CH_WIDTH-1:2*CH_WIDTH];
    end
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
  end

  always_comb begin
    pr_d   = pr_q;
    pg_d   = pg_q;
    pb_d   = pb_q;
    mx_d   = mx_q;
    g_d    = g_q;
    r_d    = r_q;
    mode_d = mode_q;
    if (en) begin
      pr_d   = PW'(r) * PW'(COEF_R);
      pg_d   = PW'(g) * PW'(COEF_G);
      pb_d   = PW'(b) * PW'(COEF_B);
      mx_d   = mx;
      g_d    = g;
      r_d    = r;
      mode_d = mode_i;
    end
  end

  always_comb begin
    sum = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + RND;
    y   = sum >> COEF_FRAC;
    luma = (y > GMAX) ? '1 : y[OUT_WIDTH-1:0];
    gray_d = gray_q;
    if (en) begin
      unique case (mode_q)
        MODE_LUMA:  gray_d = luma;
        MODE_MAX:   gray_d = scale(mx_q);
        MODE_GREEN: gray_d = scale(g_q);
        MODE_RED:   gray_d = scale(r_q);
        default:    gray_d = luma;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      mx_q   <= '0;
      g_q    <= '0;
      r_q    <= '0;
      mode_q <= MODE_LUMA;
      gray_q <= '0;
    end else begin
      pr_q   <= pr_d;
      pg_q   <= pg_d;
      pb_q   <= pb_d;
      mx_q   <= mx_d;
      g_q    <= g_d;
      r_q    <= r_d;
      mode_q <= mode_d;
      gray_q <= gray_d;
    end
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/rgb2gray_stream.sv
// AXI4-Stream RGB to packed gray writer: 2-entry skid buffer,
// stallable two-stage pixel pipeline and held output register.
module rgb2gray_stream
  import rgb2gray_pkg::*;
#(
  parameter int unsigned PPC       = 1,
  parameter int unsigned CH_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned COEF_FRAC = COEF_FRAC_DEF,
  parameter int unsigned COEF_R    = COEF_R_DEF,
  parameter int unsigned COEF_G    = COEF_G_DEF,
  parameter int unsigned COEF_B    = COEF_B_DEF,
  parameter int unsigned RED_LSB   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PPC*3*CH_WIDTH-1:0]   s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tuser,
  input  logic                        s_axis_tlast,
  input  logic [1:0]                  cfg_mode,
  output logic                        fifo_wr_en,
  output logic [PPC*OUT_WIDTH+1:0]    fifo_wr_data,
  input  logic                        fifo_full,
  output logic [15:0]                 frame_cnt
);

  localparam int DW = PPC * 3 * CH_WIDTH;
  localparam int GW = PPC * OUT_WIDTH;

  logic [1:0][DW-1:0] skid_data_q, skid_data_d;
  logic [1:0] skid_sof_q, skid_sof_d;
  logic [1:0] skid_eol_q, skid_eol_d;
  logic rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic tready_q, tready_d;

  logic en, push, pop, wr_idx;
  logic [DW-1:0] head_data;
  logic head_sof, head_eol;

  mode_e active_mode_q, active_mode_d, s1_mode;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic v1_q, v1_d, sof1_q, sof1_d, eol1_q, eol1_d;
  logic v2_q, v2_d, sof2_q, sof2_d, eol2_q, eol2_d;
  logic out_valid_q, out_valid_d;
  logic [GW+1:0] out_data_q, out_data_d;
  logic [GW-1:0] gray;

  always_comb begin
    en     = !(out_valid_q && fifo_full);
    push   = s_axis_tvalid && tready_q;
    pop    = en && (occ_q != 2'd0);
    wr_idx = rd_ptr_q ^ occ_q[0];

    head_data = skid_data_q[rd_ptr_q];
    head_sof  = skid_sof_q[rd_ptr_q];
    head_eol  = skid_eol_q[rd_ptr_q];

    skid_data_d = skid_data_q;
    skid_sof_d  = skid_sof_q;
    skid_eol_d  = skid_eol_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      skid_data_d[wr_idx] = s_axis_tdata;
      skid_sof_d[wr_idx]  = s_axis_tuser;
      skid_eol_d[wr_idx]  = s_axis_tlast;
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
    occ_d    = occ_q + 2'(push) - 2'(pop);
    tready_d = (occ_d < 2'd2);
  end

  // a sof beat uses the new mode itself; the frame keeps it
  always_comb begin
    active_mode_d = active_mode_q;
    frame_cnt_d   = frame_cnt_q;
    s1_mode       = active_mode_q;
    if (pop && head_sof) begin
      s1_mode       = mode_e'(cfg_mode);
      active_mode_d = mode_e'(cfg_mode);
      frame_cnt_d   = frame_cnt_q + 16'd1;
    end
  end

  always_comb begin
    v1_d        = v1_q;
    sof1_d      = sof1_q;
    eol1_d      = eol1_q;
    v2_d        = v2_q;
    sof2_d      = sof2_q;
    eol2_d      = eol2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (en) begin
      v1_d        = pop;
      sof1_d      = pop && head_sof;
      eol1_d      = pop && head_eol;
      v2_d        = v1_q;
      sof2_d      = sof1_q;
      eol2_d      = eol1_q;
      out_valid_d = v2_q;
      if (v2_q) begin
        out_data_d = '0;
        out_data_d[GW-1:0] = gray;
        out_data_d[GW+FLAG_SOF] = sof2_q;
        out_data_d[GW+FLAG_EOL] = eol2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_q   <= '0;
      skid_sof_q    <= '0;
      skid_eol_q    <= '0;
      rd_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
      tready_q      <= 1'b0;
      active_mode_q <= MODE_LUMA;
      frame_cnt_q   <= '0;
      v1_q          <= 1'b0;
      sof1_q        <= 1'b0;
      eol1_q        <= 1'b0;
      v2_q          <= 1'b0;
      sof2_q        <= 1'b0;
      eol2_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      skid_data_q   <= skid_data_d;
      skid_sof_q    <= skid_sof_d;
      skid_eol_q    <= skid_eol_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      tready_q      <= tready_d;
      active_mode_q <= active_mode_d;
      frame_cnt_q   <= frame_cnt_d;
      v1_q          <= v1_d;
      sof1_q        <= sof1_d;
      eol1_q        <= eol1_d;
      v2_q          <= v2_d;
      sof2_q        <= sof2_d;
      eol2_q        <= eol2_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
    end
  end

  for (genvar p = 0; p < PPC; p++) begin : g_pix
    rgb2gray_pixel #(
      .CH_WIDTH (CH_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .COEF_FRAC(COEF_FRAC),
      .COEF_R   (COEF_R),
      .COEF_G   (COEF_G),
      .COEF_B   (COEF_B),
      .RED_LSB  (RED_LSB)
    ) u_pix (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .pix_i (head_data[p*3*CH_WIDTH +: 3*CH_WIDTH]),
      .mode_i(s1_mode),
      .gray_o(gray[p*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  assign s_axis_tready = tready_q;
  assign fifo_wr_en    = out_valid_q && !fifo_full;
  assign fifo_wr_data  = out_data_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Directed bench for rgb2gray_stream at PPC=4 with
// hand-computed gray values, flags and backpressure.
module tb_rgb2gray_stream;

  localparam int PPC = 4;
  localparam int DW  = PPC * 24;
  localparam int GW  = PPC * 8;
  localparam int FW  = GW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tuser;
  logic          s_axis_tlast;
  logic [1:0]    cfg_mode;
  logic          fifo_wr_en;
  logic [FW-1:0] fifo_wr_data;
  logic          fifo_full;
  logic [15:0]   frame_cnt;

  rgb2gray_stream #(.PPC(PPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .cfg_mode     (cfg_mode),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int frames_sent = 0;
  logic [FW-1:0] got[$];
  int got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && fifo_wr_en) begin
      got.push_back(fifo_wr_data);
      got_cyc.push_back(cyc);
    end

  function automatic logic [23:0] px(input int r, input int g,
                                     input int b);
    px = {8'(b), 8'(g), 8'(r)};
  endfunction

  function automatic logic [DW-1:0] grey4(input int base);
    logic [DW-1:0] d;
    for (int k = 0; k < PPC; k++) begin
      int v;
      v = (base + k) & 255;
      d[k*24 +: 24] = px(v, v, v);
    end
    grey4 = d;
  endfunction

  function automatic logic [FW-1:0] exp_grey4(input int base,
                                              input logic sof,
                                              input logic eol);
    logic [FW-1:0] e;
    for (int k = 0; k < PPC; k++) e[k*8 +: 8] = 8'((base + k) & 255);
    e[GW]   = sof;
    e[GW+1] = eol;
    exp_grey4 = e;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic sof,
                           input logic eol);
    int n;
    logic rdy;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = sof;
    s_axis_tlast  = eol;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = s_axis_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 500) begin
        vectors++;
        miscompares++;
        $display("FAIL send_beat timeout: tready stayed 0");
        break;
      end
    end
    if (rdy && sof) frames_sent++;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int t;
    t = 0;
    while (got.size() < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (got.size() < n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_writes got %0d writes, want %0d",
               got.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
    cfg_mode = 2'd0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if (s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tready got %b want 0", s_axis_tready);
    end
    if (fifo_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wr_en got %b want 0", fifo_wr_en);
    end
    if (fifo_wr_data !== '0) begin
      miscompares++;
      $display("FAIL reset_wr_data got %h want 0", fifo_wr_data);
    end
    if (frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL release_tready got %b want 0", s_axis_tready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (s_axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL first_edge_tready got %b want 1",
               s_axis_tready);
    end
  endtask

  task automatic test_luma_latency();
    logic [FW-1:0] exp;
    logic want;
    got.delete();
    got_cyc.delete();
    cfg_mode = 2'd0;
    s_axis_tdata = {px(10, 200, 50), px(0, 0, 0),
                    px(255, 0, 0), px(255, 255, 255)};
    s_axis_tuser = 1'b1;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    frames_sent++;
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
    exp = {1'b0, 1'b1, 8'd126, 8'd0, 8'd77, 8'd255};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      want = (i == 3);
      vectors++;
      if (fifo_wr_en !== want) begin
        miscompares++;
        $display("FAIL latency_wr_en edge+%0d got %b want %b",
                 i, fifo_wr_en, want);
      end
    end
    vectors++;
    if (fifo_wr_data !== exp) begin
      miscompares++;
      $display("FAIL luma_data got %h want %h", fifo_wr_data, exp);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (frame_cnt !== 16'(frames_sent)) begin
      miscompares++;
      $display("FAIL luma_frame_cnt got %0d want %0d",
               frame_cnt, frames_sent);
    end
  endtask

  task automatic test_modes();
    logic [DW-1:0] beat;
    logic [1:0] mode_t[6];
    logic sof_t[6];
    logic eol_t[6];
    logic [FW-1:0] exp_t[6];
    beat = {px(255, 0, 0), px(0, 0, 255),
            px(90, 30, 60), px(10, 200, 50)};
    mode_t = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd2};
    sof_t  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    eol_t  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t[0] = {1'b0, 1'b1, 8'd255, 8'd255, 8'd90, 8'd200};
    exp_t[1] = {1'b0, 1'b1, 8'd0, 8'd0, 8'd30, 8'd200};
    exp_t[2] = {1'b0, 1'b1, 8'd255, 8'd0, 8'd90, 8'd10};
    exp_t[3] = {1'b0, 1'b0, 8'd255, 8'd0, 8'd90, 8'd10};
    exp_t[4] = {1'b0, 1'b1, 8'd77, 8'd29, 8'd51, 8'd126};
    exp_t[5] = {1'b1, 1'b0, 8'd77, 8'd29, 8'd51, 8'd126};
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      cfg_mode = mode_t[i];
      send_beat(beat, sof_t[i], eol_t[i]);
      repeat (3) @(posedge clk);
      #1;
    end
    wait_writes(6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_t[i]) begin
        miscompares++;
        $display("FAIL mode_step%0d got %h want %h",
                 i, got[i], exp_t[i]);
      end
    end
    cfg_mode = 2'd0;
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] exp;
    got.delete();
    got_cyc.delete();
    cfg_mode = 2'd0;
    for (int i = 0; i < 16; i++)
      send_beat(grey4(i * 4), i == 0, i == 15);
    wait_writes(16);
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      exp = exp_grey4(i * 4, i == 0, i == 15);
      vectors++;
      if (got[i] !== exp) begin
        miscompares++;
        $display("FAIL b2b_beat%0d got %h want %h", i, got[i], exp);
      end
    end
    if (got.size() >= 16) begin
      vectors++;
      if (got_cyc[15] - got_cyc[0] !== 15) begin
        miscompares++;
        $display("FAIL b2b_span got %0d cycles want 15",
                 got_cyc[15] - got_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] exp;
    bit done;
    got.delete();
    got_cyc.delete();
    cfg_mode = 2'd0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++)
          send_beat(grey4(i * 3 + 1), i == 0, i == 63);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          fifo_full = 1'($urandom_range(0, 1));
        end
      end
    join
    fifo_full = 1'b0;
    wait_writes(64);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (got.size() !== 64) begin
      miscompares++;
      $display("FAIL bp_count got %0d writes want 64", got.size());
    end
    for (int i = 0; i < 64 && i < got.size(); i++) begin
      exp = exp_grey4(i * 3 + 1, i == 0, i == 63);
      vectors++;
      if (got[i] !== exp) begin
        miscompares++;
        $display("FAIL bp_beat%0d got %h want %h", i, got[i], exp);
      end
    end
  endtask

  task automatic test_flags();
    logic [FW-1:0] exp;
    got.delete();
    got_cyc.delete();
    cfg_mode = 2'd0;
    for (int i = 0; i < 416; i++)
      send_beat(grey4(i * 4), i == 0, i == 415);
    wait_writes(416);
    for (int i = 0; i < 416 && i < got.size(); i++) begin
      exp = exp_grey4(i * 4, i == 0, i == 415);
      vectors++;
      if (got[i] !== exp) begin
        miscompares++;
        $display("FAIL flags_beat%0d got %h want %h",
                 i, got[i], exp);
      end
    end
    vectors++;
    if (frame_cnt !== 16'(frames_sent)) begin
      miscompares++;
      $display("FAIL flags_frame_cnt got %0d want %0d",
               frame_cnt, frames_sent);
    end
  endtask

  task automatic test_frame_wrap();
    got.delete();
    got_cyc.delete();
    @(negedge clk);
    dut.frame_cnt_q <= 16'hFFFE;
    frames_sent = 32'hFFFE;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      send_beat(grey4(i), 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (frame_cnt !== 16'(frames_sent)) begin
        miscompares++;
        $display("FAIL wrap_frame_cnt%0d got %h want %h",
                 i, frame_cnt, 16'(frames_sent));
      end
    end
    wait_writes(2);
  endtask

  task automatic test_reset_midstream();
    logic [FW-1:0] exp;
    got.delete();
    got_cyc.delete();
    cfg_mode = 2'd0;
    fifo_full = 1'b1;
    s_axis_tdata = grey4(7);
    s_axis_tuser = 1'b1;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL skid_full_tready got %b want 0",
               s_axis_tready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (fifo_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst_wr_en got %b want 0", fifo_wr_en);
    end
    if (fifo_wr_data !== '0) begin
      miscompares++;
      $display("FAIL async_rst_data got %h want 0", fifo_wr_data);
    end
    if (s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst_tready got %b want 0",
               s_axis_tready);
    end
    if (frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL async_rst_frame_cnt got %0d want 0",
               frame_cnt);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
    frames_sent = 0;
    @(negedge clk);
    rst_n = 1'b1;
    fifo_full = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (got.size() !== 0) begin
      miscompares++;
      $display("FAIL stale_write got %0d writes want 0", got.size());
    end
    cfg_mode = 2'd2;
    send_beat({px(255, 0, 0), px(0, 0, 255),
               px(90, 30, 60), px(10, 200, 50)}, 1'b1, 1'b1);
    wait_writes(1);
    exp = {1'b1, 1'b1, 8'd0, 8'd0, 8'd30, 8'd200};
    if (got.size() > 0) begin
      vectors++;
      if (got[0] !== exp) begin
        miscompares++;
        $display("FAIL post_rst_beat got %h want %h", got[0], exp);
      end
    end
    vectors++;
    if (frame_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL post_rst_frame_cnt got %0d want 1", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_luma_latency();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_flags();
    test_frame_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
